// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receiver for a multiplexed active-low 7-segment display bus.
// Synchronises and deglitches each scan step, then decodes the cathode pattern per digit.
module seg_scan_capture #(
  parameter int NDIG    = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic        Clock,
  input  logic        clr,
  input  logic [6:0]  CA_in,
  input  logic [7:0]  AN_in,
  output logic [31:0] digits,
  output logic [7:0]  dvalid,
  output logic [7:0]  blank,
  output logic        frame_done,
  output logic        seg_err,
  output logic        stale
);

  localparam int          RW       = $clog2(SETTLE + 1);
  localparam int          IW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  DIG_MASK = 8'((16'd1 << NDIG) - 16'd1);
  localparam logic [14:0] BUS_IDLE = {8'hFF, 7'h7F};

  function automatic logic [4:0] seg_decode(input logic [6:0] ca);
    logic [4:0] r;
    case (ca)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [14:0]   s1_q, s2_q, prev_q;
  logic [RW-1:0] run_q, run_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   digits_q, digits_d;
  logic [7:0]    dvalid_q, dvalid_d, blank_q, blank_d;
  logic          frame_q, frame_d, err_q, err_d, stale_q, stale_d;

  logic          change_s, capture_s, hit_s, onehot_s;
  logic [7:0]    an_act_s, seen_or_s;
  logic [2:0]    idx_s;
  logic [4:0]    dec_s;

  // Next-state logic: run/capture detection, digit decode, frame and idle tracking.
  always_comb begin
    change_s = (s2_q != prev_q);
    if (change_s) begin
      run_d = RW'(1);
    end else if (run_q != RW'(SETTLE)) begin
      run_d = run_q + RW'(1);
    end else begin
      run_d = run_q;
    end
    // A change can complete a run only when SETTLE is 1; otherwise the run must just reach SETTLE.
    capture_s = (run_d == RW'(SETTLE)) && (change_s || (run_q != RW'(SETTLE)));

    an_act_s = ~s2_q[14:7] & DIG_MASK;
    hit_s    = capture_s && (an_act_s != 8'd0);
    onehot_s = ((an_act_s & (an_act_s - 8'd1)) == 8'd0);
    idx_s    = 3'd0;
    for (int b = 0; b < 8; b++) begin
      idx_s = an_act_s[b] ? 3'(b) : idx_s;
    end
    dec_s     = seg_decode(s2_q[6:0]);
    seen_or_s = seen_q | (8'd1 << idx_s);

    digits_d = digits_q;
    dvalid_d = dvalid_q;
    blank_d  = blank_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    if (hit_s) begin
      if (onehot_s) begin
        if (dec_s[4]) begin
          digits_d[4*idx_s +: 4] = dec_s[3:0];
          dvalid_d[idx_s]        = 1'b1;
          blank_d[idx_s]         = 1'b0;
        end else if (s2_q[6:0] == 7'h7F) begin
          dvalid_d[idx_s] = 1'b1;
          blank_d[idx_s]  = 1'b1;
        end else begin
          err_d           = 1'b1;
          dvalid_d[idx_s] = 1'b0;
        end
        if ((seen_or_s & DIG_MASK) == DIG_MASK) begin
          frame_d = 1'b1;
          seen_d  = 8'd0;
        end else begin
          seen_d = seen_or_s;
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      seen_d = seen_q;
    end

    if (hit_s) begin
      idle_d = '0;
    end else if (idle_q != IW'(TIMEOUT)) begin
      idle_d = idle_q + IW'(1);
    end else begin
      idle_d = idle_q;
    end
    stale_d = (idle_d == IW'(TIMEOUT));
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      s1_q     <= BUS_IDLE;
      s2_q     <= BUS_IDLE;
      prev_q   <= BUS_IDLE;
      run_q    <= '0;
      idle_q   <= '0;
      seen_q   <= 8'd0;
      digits_q <= 32'd0;
      dvalid_q <= 8'd0;
      blank_q  <= 8'd0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      s1_q     <= {AN_in, CA_in};
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      run_q    <= run_d;
      idle_q   <= idle_d;
      seen_q   <= seen_d;
      digits_q <= digits_d;
      dvalid_q <= dvalid_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
    end
  end

  assign digits     = digits_q;
  assign dvalid     = dvalid_q;
  assign blank      = blank_q;
  assign frame_done = frame_q;
  assign seg_err    = err_q;
  assign stale      = stale_q;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receiver for the multiplexed 7-segment display bus (active-low CA cathodes, active-low AN digit enables) that the display driver produces.
- Samples the bus, deglitches each scan step and decodes the cathode pattern back to a 4-bit hex value per digit.
- Reports per-digit values, frame completion, illegal patterns and a stalled scan.
- Used as an on-board loopback checker for display drivers and as a bench monitor.

Parameters:
- NDIG, 4, number of active digits, AN_in[NDIG-1:0] (1..8); higher AN bits ignored.
- SETTLE, 2, consecutive synchronised cycles a bus value must hold before capture (1..15).
- TIMEOUT, 1000, cycles without a capture before stale asserts (>= 2).

Ports:
- Clock  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- CA_in  in  7  cathodes, active low; CA_in[6]=a ... CA_in[0]=g.
- AN_in  in  8  digit enables, active low, one-hot-zero when a digit is driven.
- digits  out  32  4-bit value per digit; digit i at [4i+3:4i].
- dvalid  out  8  digit i holds a decoded value or blank since reset.
- blank  out  8  digit i last captured as all segments off.
- frame_done  out  1  one-cycle pulse: every digit 0..NDIG-1 captured since last pulse.
- seg_err  out  1  one-cycle pulse: illegal AN or CA pattern at a capture point.
- stale  out  1  no capture for TIMEOUT cycles.

Behaviour:
- Reset (clr=0, async): digits=0, dvalid=0, blank=0, frame_done=0, seg_err=0, stale=0.
  - Synchronisers load AN=8'hFF and CA=7'h7F.
  - Run counter, seen mask and idle counter load 0.
- Input path: two-flop synchroniser on {AN_in, CA_in}, 15 bits, producing s2.
- Run counter:
  - Increments, saturating at SETTLE, while s2 equals its previous-cycle value.
  - Loads 1 on any change.
  - Capture point: the cycle where run transitions to SETTLE. Exactly one per stable interval.
- Latency: a value applied before edge k and held is captured, and outputs updated, at edge k+1+SETTLE.
- At a capture point, with AN masked to bits [NDIG-1:0]:
  - All ones: inter-digit blanking. No update, no error.
  - Exactly one zero at index i: decode CA.
    - Hex match: digits[i]=value, dvalid[i]=1, blank[i]=0.
    - CA=7'h7F: blank[i]=1, dvalid[i]=1, digits[i] unchanged.
    - Any other pattern: seg_err pulse; dvalid[i]=0; digits[i] and blank[i] unchanged.
    - In all three cases set seen[i].
  - Two or more zeros: seg_err pulse, no update.
- Decode table, CA[6:0] -> value:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b
  - 0110001->C, 1000010->d, 0110000->E, 0111000->F
- Frame tracking:
  - When seen (including the current capture) equals all ones over NDIG bits, frame_done pulses on the next edge and seen clears to 0.
  - A repeat capture of an already-seen digit is not an error.
- Idle counter:
  - Counts cycles since the last capture point (any outcome except AN all ones).
  - Saturates at TIMEOUT; stale=1 while saturated.
  - A capture clears the counter and stale at the same edge.
- Mid-operation reset: all state returns to reset values immediately. The first capture after release needs the full SETTLE run.
- Glitches: a bus value shorter than SETTLE synchronised cycles is never captured.

Test Plan:
1. Reset then steady scan. Drive AN=FE/FD/FB/F7 with CA=1001111/0010010/0000110/1001100, each held 6 cycles.
   -> digits[15:0]=16'h4321, dvalid=4'hF, one frame_done pulse after the 4th digit, seg_err never asserts.
2. SETTLE=2. Drive a 1-cycle glitch AN=FD, CA=0000000 between two stable digit-0 steps.
   -> digits[7:4] unchanged, no seg_err, no capture.
3. Drive AN=FB with CA=1111111, held 6 cycles.
   -> blank[2]=1, dvalid[2]=1, digits[11:8] unchanged.
   Then drive CA=1010101.
   -> seg_err single pulse, dvalid[2]=0.
4. Drive AN=FC (two digits low) with valid CA.
   -> seg_err pulse, no digit change, no frame_done.
5. TIMEOUT=20. Hold AN=FF for 25 cycles.
   -> stale=1 after 20 cycles. Then a valid digit-1 step clears stale at its capture edge.
6. Pull clr low mid-scan after digits 0 and 1 are captured.
   -> all outputs 0 immediately. After release, a full 4-digit scan gives exactly one frame_done.
